uart_rx_core: RTL and testbench



---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_sync.sv | 30 +++
 rtl/uart_rx_core.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
// Contents: receiver state enum, data_bits encodings, default oversampling
// ratio, and char_bits() mapping a data_bits code to a character length.
package uart_pkg;

  localparam int OSR_DEFAULT = 16;

  localparam logic [1:0] DB_5 = 2'd0;
  localparam logic [1:0] DB_6 = 2'd1;
  localparam logic [1:0] DB_7 = 2'd2;
  localparam logic [1:0] DB_8 = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  function automatic logic [3:0] char_bits(input logic [1:0] db);
    logic [3:0] n;
    case (db)
      DB_5:    n = 4'd5;
      DB_6:    n = 4'd6;
      DB_7:    n = 4'd7;
      DB_8:    n = 4'd8;
      default: n = 4'd8;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchronizer for an asynchronous input
// Ports: clk, rstn (async active-low), d (async in), q (synchronized out).
// All stages reset to 1 so an idle-high line never looks like a start bit.
module uart_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[DEPTH-2:0], d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: 16x oversampled deframer feeding the RX FIFO
// Ports:
//   clk, rstn           clock, async active-low reset
//   baud_tick           one-clk enable at OSR x baud
//   rxd                 async serial input, idle high
//   data_bits           0..3 -> 5..8 bit characters
//   parity_en/odd       parity present / odd parity select
//   fifo_full           RX FIFO full, checked on the commit cycle
//   rx_data, rx_wr      received character and its one-clk write strobe
//   parity_err, frame_err, break_det   status of the last committed character
//   overrun             one-clk pulse when a character is dropped
//   busy                receiver not idle
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OSR         = OSR_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       baud_tick,
  input  logic       rxd,
  input  logic [1:0] data_bits,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_wr,
  output logic       parity_err,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(OSR);
  localparam logic [TW-1:0] HALF_TICK = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OSR - 1);

  logic rxs;
  logic samp;

  uart_sync #(.DEPTH(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rxd),
    .q    (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // rxs from the two previous ticks; with the current rxs this forms the
  // three-tick window ending at the sample tick.
  logic [1:0] hist_q;
  logic [1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (baud_tick) hist_d = {hist_q[0], rxs};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) hist_q <= '1;
    else       hist_q <= hist_d;
  end

  assign samp = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign samp = rxs;
`endif

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic [1:0]    cfg_bits_q, cfg_bits_d;
  logic          cfg_par_q, cfg_par_d;
  logic          cfg_odd_q, cfg_odd_d;
  logic          pbit_q, pbit_d;
  logic          pend_q, pend_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          brk_q, brk_d;

  logic [2:0] last_bit;
  assign last_bit = 3'(char_bits(cfg_bits_q) - 4'd1);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    data_d     = data_q;
    cfg_bits_d = cfg_bits_q;
    cfg_par_d  = cfg_par_q;
    cfg_odd_d  = cfg_odd_q;
    pbit_d     = pbit_q;
    pend_d     = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    brk_d      = brk_q;

    if (baud_tick) tick_d = tick_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (baud_tick && !rxs) begin
          cfg_bits_d = data_bits;
          cfg_par_d  = parity_en;
          cfg_odd_d  = parity_odd;
          tick_d     = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (baud_tick && tick_q == HALF_TICK) begin
          if (samp) begin
            state_d = ST_IDLE;
          end else begin
            tick_d  = '0;
            bit_d   = '0;
            data_d  = '0;
            pbit_d  = 1'b0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick && tick_q == FULL_TICK) begin
          data_d[bit_q] = samp;
          bit_d         = bit_q + 3'd1;
          if (bit_q == last_bit) state_d = cfg_par_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (baud_tick && tick_q == FULL_TICK) begin
          pbit_d  = samp;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Status regs load on the sample edge so they are already valid
        // on the commit cycle that follows; pend_q marks that cycle.
        if (pend_q) begin
          state_d = ferr_q ? ST_WAIT_HIGH : ST_IDLE;
        end else if (baud_tick && tick_q == FULL_TICK) begin
          ferr_d = ~samp;
          perr_d = cfg_par_q & ((^data_q) ^ pbit_q ^ cfg_odd_q);
          brk_d  = (data_q == 8'h00) & ~pbit_q & ~samp;
          pend_d = 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (baud_tick && rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      data_q     <= '0;
      cfg_bits_q <= '0;
      cfg_par_q  <= 1'b0;
      cfg_odd_q  <= 1'b0;
      pbit_q     <= 1'b0;
      pend_q     <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      data_q     <= data_d;
      cfg_bits_q <= cfg_bits_d;
      cfg_par_q  <= cfg_par_d;
      cfg_odd_q  <= cfg_odd_d;
      pbit_q     <= pbit_d;
      pend_q     <= pend_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      brk_q      <= brk_d;
    end
  end

  assign rx_data    = data_q;
  assign rx_wr      = pend_q & ~fifo_full;
  assign overrun    = pend_q & fifo_full;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign break_det  = brk_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - self-checking bench for uart_rx_core
module tb_uart_rx_core;

  localparam int TICK_DIV = 4;
  localparam int BIT_CLK  = 16 * TICK_DIV;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] data_bits = 2'd3;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_wr, parity_err, frame_err, break_det, overrun, busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
  } rec_t;

  rec_t wr_q[$];
  rec_t ov_rec;
  int   ov_cnt = 0;
  int   both_cnt = 0;

  uart_rx_core dut (
    .clk        (clk),
    .rstn       (rstn),
    .baud_tick  (baud_tick),
    .rxd        (rxd),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .fifo_full  (fifo_full),
    .rx_data    (rx_data),
    .rx_wr      (rx_wr),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .break_det  (break_det),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_wr) wr_q.push_back({rx_data, parity_err, frame_err, break_det});
    if (overrun) begin
      ov_cnt++;
      ov_rec = {rx_data, parity_err, frame_err, break_det};
    end
    if (rx_wr && overrun) both_cnt++;
  end

  // Serial line model: start, nb data bits LSB first, optional parity
  // (flip inverts the correct value), one stop bit of value stopv, then idle.
  task automatic send_frame(input logic [7:0] d, input int nb, input bit pen,
                            input bit podd, input bit flip, input bit stopv);
    bit p;
    p = podd ^ flip;
    rxd = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    for (int i = 0; i < nb; i++) begin
      rxd = d[i];
      p   = p ^ d[i];
      repeat (BIT_CLK) @(posedge clk);
    end
    if (pen) begin
      rxd = p;
      repeat (BIT_CLK) @(posedge clk);
    end
    rxd = stopv;
    repeat (BIT_CLK) @(posedge clk);
    rxd = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    ov_cnt   = 0;
    both_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (rx_wr !== 1'b0) begin errors++; $display("FAIL reset_rx_wr got=%b exp=0", rx_wr); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    checks++; if ({parity_err, frame_err, break_det} !== 3'b000)
      begin errors++; $display("FAIL reset_flags got=%b exp=000", {parity_err, frame_err, break_det}); end
  endtask

  task automatic test_8n1();
    clear_mon();
    data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
    send_frame(8'hA5, 8, 0, 0, 0, 1);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL 8n1_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'hA5, 3'b000}) begin errors++; $display("FAIL 8n1_word got=%h exp=%h", wr_q[0], {8'hA5, 3'b000}); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy got=%b exp=0", busy); end
  endtask

  task automatic test_parity();
    clear_mon();
    data_bits = 2'd2; parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h35, 7, 1, 0, 1, 1);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL par_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'h35, 3'b100}) begin errors++; $display("FAIL par_word got=%h exp=%h", wr_q[0], {8'h35, 3'b100}); end
    end
  endtask

  task automatic test_frame();
    clear_mon();
    data_bits = 2'd0; parity_en = 1'b0; parity_odd = 1'b0;
    send_frame(8'h1F, 5, 0, 0, 0, 0);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL frm_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'h1F, 3'b010}) begin errors++; $display("FAIL frm_word got=%h exp=%h", wr_q[0], {8'h1F, 3'b010}); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frm_busy got=%b exp=0", busy); end
  endtask

  task automatic test_break();
    clear_mon();
    data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
    rxd = 1'b0;
    repeat (3 * 10 * BIT_CLK) @(posedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_held got=%b exp=1", busy); end
    rxd = 1'b1;
    repeat (2 * BIT_CLK) @(posedge clk);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL brk_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'h00, 3'b011}) begin errors++; $display("FAIL brk_word got=%h exp=%h", wr_q[0], {8'h00, 3'b011}); end
    end
    clear_mon();
    send_frame(8'h5A, 8, 0, 0, 0, 1);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL brk_next_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'h5A, 3'b000}) begin errors++; $display("FAIL brk_next_word got=%h exp=%h", wr_q[0], {8'h5A, 3'b000}); end
    end
  endtask

  task automatic test_overrun();
    clear_mon();
    data_bits = 2'd3; parity_en = 1'b0; parity_odd = 1'b0;
    #1 fifo_full = 1'b1;
    send_frame(8'h3C, 8, 0, 0, 0, 1);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL ovr_wr got=%0d exp=0", wr_q.size()); end
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL ovr_pulse got=%0d exp=1", ov_cnt); end
    checks++; if (ov_rec[2:0] !== 3'b000) begin errors++; $display("FAIL ovr_flags got=%b exp=000", ov_rec[2:0]); end
    // A dropped 7E1 character with a bad parity bit still reports its status.
    clear_mon();
    data_bits = 2'd2; parity_en = 1'b1;
    send_frame(8'h12, 7, 1, 0, 1, 1);
    checks++; if (ov_cnt != 1) begin errors++; $display("FAIL ovr2_pulse got=%0d exp=1", ov_cnt); end
    checks++; if (ov_rec[2:0] !== 3'b100) begin errors++; $display("FAIL ovr2_flags got=%b exp=100", ov_rec[2:0]); end
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL ovr2_hold got=%b exp=1", parity_err); end
    #1 fifo_full = 1'b0;
    clear_mon();
    data_bits = 2'd3; parity_en = 1'b0;
    send_frame(8'hC3, 8, 0, 0, 0, 1);
    checks++; if (ov_cnt != 0) begin errors++; $display("FAIL ovr_next_ov got=%0d exp=0", ov_cnt); end
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL ovr_next_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'hC3, 3'b000}) begin errors++; $display("FAIL ovr_next_word got=%h exp=%h", wr_q[0], {8'hC3, 3'b000}); end
    end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    clear_mon();
    saw_busy = 1'b0;
    rxd = 1'b0;
    repeat (3 * TICK_DIV) @(posedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    repeat (4 * BIT_CLK) @(posedge clk);
    checks++; if (saw_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_seen got=%b exp=1", saw_busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL glitch_wr got=%0d exp=0", wr_q.size()); end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    logic [7:0] d;
    clear_mon();
    d = 8'h81;
    data_bits = 2'd3; parity_en = 1'b0;
    rxd = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      repeat (BIT_CLK / 2 - TICK_DIV / 2) @(posedge clk);
      if (i == 3) rxd = ~d[i];
      repeat (TICK_DIV) @(posedge clk);
      rxd = d[i];
      repeat (BIT_CLK / 2 - TICK_DIV / 2) @(posedge clk);
    end
    rxd = 1'b1;
    repeat (3 * BIT_CLK) @(posedge clk);
    checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL maj_count got=%0d exp=1", wr_q.size()); end
    if (wr_q.size() > 0) begin
      checks++; if (wr_q[0] !== {8'h81, 3'b000}) begin errors++; $display("FAIL maj_word got=%h exp=%h", wr_q[0], {8'h81, 3'b000}); end
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      logic [7:0] d, m;
      int  nb;
      bit  pen, podd, flip, stopv;
      rec_t exp;
      d     = 8'($urandom);
      data_bits  = 2'($urandom_range(0, 3));
      nb    = 5 + int'(data_bits);
      pen   = 1'($urandom_range(0, 1));
      podd  = 1'($urandom_range(0, 1));
      flip  = pen & 1'($urandom_range(0, 1));
      stopv = ($urandom_range(0, 3) != 0);
      if (n == 0) begin d = 8'h00; stopv = 1'b0; end
      parity_en  = pen;
      parity_odd = podd;
      m = 8'((16'd1 << nb) - 16'd1) & d;
      exp.d  = m;
      exp.pe = pen & flip;
      exp.fe = ~stopv;
      // Parity bit on the line is 0 when the data's xor equals podd^flip.
      exp.bk = (m == 8'h00) & ~stopv & (~pen | ~(podd ^ flip));
      clear_mon();
      send_frame(d, nb, pen, podd, flip, stopv);
      checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=1", n, wr_q.size()); end
      if (wr_q.size() > 0) begin
        checks++; if (wr_q[0] !== exp) begin errors++; $display("FAIL rnd%0d_word got=%h exp=%h", n, wr_q[0], exp); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    data_bits = 2'd3; parity_en = 1'b0;
    rxd = 1'b0;
    repeat (BIT_CLK) @(posedge clk);
    rxd = 1'b1;
    repeat (3 * BIT_CLK) @(posedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #1 rstn = 1'b0;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_reset got=%b exp=0", busy); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL mid_data_reset got=%h exp=00", rx_data); end
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (12 * BIT_CLK) @(posedge clk);
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL mid_wr got=%0d exp=0", wr_q.size()); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    test_reset();
    #1 rstn = 1'b1;
    repeat (4 * BIT_CLK) @(posedge clk);
    test_8n1();
    test_parity();
    test_frame();
    test_break();
    test_overrun();
    test_glitch();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    test_random();
    test_reset_midframe();
    checks++; if (both_cnt != 0) begin errors++; $display("FAIL wr_and_overrun got=%0d exp=0", both_cnt); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
